park: RTL and testbench

- Park transform stage directly downstream of the Clarke stage: consumes stationary-frame alpha/beta plus rotor-angle sin/cos and produces rotating-frame d/q currents.
  - d = alpha*cos + beta*sin
  - q = beta*cos - alpha*sin
- Area-lean: a single shared signed multiplier/accumulator, time-multiplexed over four cycles under a small FSM with start/done handshake.
- Same fixed-point format as the Clarke stage, so the two chain directly.

---
 rtl/motor_ctrl_pkg.sv | 41 ++++
 rtl/park_mac.sv | 48 ++++
 rtl/park.sv | 101 ++++++++++
 tb/tb_park.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/motor_ctrl_pkg.sv
// rtl/motor_ctrl_pkg.sv - shared fixed-point defaults, Park FSM states and rounding helper
package motor_ctrl_pkg;

    localparam int D_WIDTH_DEF = 18;
    localparam int Q_BITS_DEF  = 15;

    typedef enum logic [2:0] {
        IDLE,
        MUL0,
        MUL1,
        MUL2,
        MUL3
    } park_state_t;

    typedef enum logic [1:0] {
        HOLD,
        LOAD,
        ADD,
        SUB
    } mac_op_t;

    // Round half up, drop qb fraction bits, clamp to a dw-bit signed range.
    function automatic logic signed [63:0] round_sat(input logic signed [63:0] x,
                                                     input int dw,
                                                     input int qb);
        logic signed [63:0] v_r;
        logic signed [63:0] v_max;
        logic signed [63:0] v_min;
        v_r   = (x + (64'sd1 <<< (qb - 1))) >>> qb;
        v_max = (64'sd1 <<< (dw - 1)) - 64'sd1;
        v_min = -v_max - 64'sd1;
        if (v_r > v_max) begin
            return v_max;
        end
        if (v_r < v_min) begin
            return v_min;
        end
        return v_r;
    endfunction

endpackage

// File: rtl/park_mac.sv
// rtl/park_mac.sv - shared signed multiplier with load/add/sub accumulator
module park_mac
    import motor_ctrl_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF,
    parameter int Q_BITS  = Q_BITS_DEF
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  mac_op_t                   i_op,
    input  logic signed [D_WIDTH-1:0] i_a,
    input  logic signed [D_WIDTH-1:0] i_b,
    output logic signed [D_WIDTH-1:0] o_res
);

    localparam int ACC_W = 2 * D_WIDTH + 1;

    logic signed [2*D_WIDTH-1:0] w_prod;
    logic signed [ACC_W-1:0]     w_prod_ext;
    logic signed [ACC_W-1:0]     w_acc_next;
    logic signed [ACC_W-1:0]     r_acc;

    assign w_prod     = i_a * i_b;
    assign w_prod_ext = {w_prod[2*D_WIDTH-1], w_prod};

    always_comb begin
        w_acc_next = r_acc;
        case (i_op)
            LOAD:    w_acc_next = w_prod_ext;
            ADD:     w_acc_next = r_acc + w_prod_ext;
            SUB:     w_acc_next = r_acc - w_prod_ext;
            default: w_acc_next = r_acc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_acc_next;
        end
    end

    // Rounded view of the value being written this cycle, so the caller can
    // capture a finished sum on the same edge that completes it.
    assign o_res = D_WIDTH'(round_sat(64'(w_acc_next), D_WIDTH, Q_BITS));

endmodule

// File: rtl/park.sv
// rtl/park.sv - Park transform, one shared MAC sequenced over four cycles
module park
    import motor_ctrl_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF,
    parameter int Q_BITS  = Q_BITS_DEF
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      start,
    input  logic signed [D_WIDTH-1:0] alpha,
    input  logic signed [D_WIDTH-1:0] beta,
    input  logic signed [D_WIDTH-1:0] sin_theta,
    input  logic signed [D_WIDTH-1:0] cos_theta,
    output logic                      busy,
    output logic signed [D_WIDTH-1:0] d,
    output logic signed [D_WIDTH-1:0] q,
    output logic                      done
);

    park_state_t r_state;
    park_state_t w_state_next;

    logic signed [D_WIDTH-1:0] r_alpha;
    logic signed [D_WIDTH-1:0] r_beta;
    logic signed [D_WIDTH-1:0] r_sin;
    logic signed [D_WIDTH-1:0] r_cos;
    logic signed [D_WIDTH-1:0] r_d_hold;
    logic signed [D_WIDTH-1:0] r_d;
    logic signed [D_WIDTH-1:0] r_q;
    logic                      r_done;

    mac_op_t                   w_op;
    logic signed [D_WIDTH-1:0] w_a;
    logic signed [D_WIDTH-1:0] w_b;
    logic signed [D_WIDTH-1:0] w_res;

    always_comb begin
        w_state_next = r_state;
        w_op         = HOLD;
        w_a          = '0;
        w_b          = '0;
        case (r_state)
            IDLE: if (start) w_state_next = MUL0;
            MUL0: begin w_op = LOAD; w_a = r_alpha; w_b = r_cos; w_state_next = MUL1; end
            MUL1: begin w_op = ADD;  w_a = r_beta;  w_b = r_sin; w_state_next = MUL2; end
            MUL2: begin w_op = LOAD; w_a = r_beta;  w_b = r_cos; w_state_next = MUL3; end
            MUL3: begin w_op = SUB;  w_a = r_alpha; w_b = r_sin; w_state_next = IDLE; end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            r_state  <= IDLE;
            r_alpha  <= '0;
            r_beta   <= '0;
            r_sin    <= '0;
            r_cos    <= '0;
            r_d_hold <= '0;
            r_d      <= '0;
            r_q      <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (r_state == MUL3);
            if (r_state == IDLE && start) begin
                r_alpha <= alpha;
                r_beta  <= beta;
                r_sin   <= sin_theta;
                r_cos   <= cos_theta;
            end
            if (r_state == MUL1) begin
                r_d_hold <= w_res;
            end
            // d is parked until q finishes so both outputs change on the same edge.
            if (r_state == MUL3) begin
                r_d <= r_d_hold;
                r_q <= w_res;
            end
        end
    end

    park_mac #(
        .D_WIDTH(D_WIDTH),
        .Q_BITS (Q_BITS)
    ) u_mac (
        .clk  (clk),
        .rstb (rstb),
        .i_op (w_op),
        .i_a  (w_a),
        .i_b  (w_b),
        .o_res(w_res)
    );

    assign busy = (r_state != IDLE);
    assign d    = r_d;
    assign q    = r_q;
    assign done = r_done;

endmodule

// File: tb/tb_park.sv
// tb/tb_park.sv - directed self-checking bench for park
module tb_park;

    logic               clk;
    logic               rstb;
    logic               start;
    logic signed [17:0] alpha;
    logic signed [17:0] beta;
    logic signed [17:0] sin_theta;
    logic signed [17:0] cos_theta;
    logic               busy;
    logic signed [17:0] d;
    logic signed [17:0] q;
    logic               done;

    int n_total = 0;
    int n_bad   = 0;

    park u_dut (
        .clk      (clk),
        .rstb     (rstb),
        .start    (start),
        .alpha    (alpha),
        .beta     (beta),
        .sin_theta(sin_theta),
        .cos_theta(cos_theta),
        .busy     (busy),
        .d        (d),
        .q        (q),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int a, input int b, input int s, input int c);
        alpha     = 18'(a);
        beta      = 18'(b);
        sin_theta = 18'(s);
        cos_theta = 18'(c);
    endtask

    task automatic scramble();
        set_ops(int'($urandom), int'($urandom), int'($urandom), int'($urandom));
    endtask

    // One transform: start in cycle N, busy N+1..N+4, done only in N+5.
    task automatic run_op(input string tag, input int a, input int b, input int s, input int c,
                          input int ed, input int eq);
        set_ops(a, b, s, c);
        start = 1'b1;
        tick();
        start = 1'b0;
        scramble();
        for (int k = 0; k < 4; k++) begin
            chk({tag, ".busy"}, int'(busy), 1);
            chk({tag, ".early_done"}, int'(done), 0);
            tick();
        end
        chk({tag, ".done"}, int'(done), 1);
        chk({tag, ".busy_in_done"}, int'(busy), 0);
        chk({tag, ".d"}, int'(d), ed);
        chk({tag, ".q"}, int'(q), eq);
        tick();
        chk({tag, ".done_drop"}, int'(done), 0);
        chk({tag, ".d_hold"}, int'(d), ed);
        chk({tag, ".q_hold"}, int'(q), eq);
    endtask

    initial begin
        int ba[3];
        int bb[3];
        int bs[3];
        int bc[3];
        int bd[3];
        int bq[3];

        rstb  = 1'b1;
        start = 1'b0;
        set_ops(0, 0, 0, 0);
        tick();
        tick();
        chk("rst.d", int'(d), 0);
        chk("rst.q", int'(q), 0);
        chk("rst.done", int'(done), 0);
        chk("rst.busy", int'(busy), 0);
        rstb = 1'b0;
        tick();

        run_op("theta0",  16384, -8192, 0, 32768, 16384, -8192);
        run_op("theta90", 16384, -8192, 32768, 0, -8192, -16384);
        run_op("rnd_p1",  1, 0, 0, 16384, 1, 0);
        run_op("rnd_m1",  -1, 0, 0, 16384, 0, 0);
        run_op("rnd_p3",  3, 0, 0, 16384, 2, 0);
        run_op("rnd_m3",  -3, 0, 0, 16384, -1, 0);
        run_op("sat_pos", 131071, 131071, 32768, 32768, 131071, 0);
        run_op("sat_neg", -131072, -131072, 32768, 32768, -131072, 0);

        ba = '{1000, -3000, 100};
        bb = '{2000, 500, -200};
        bs = '{16384, 0, -32768};
        bc = '{16384, 32768, 0};
        bd = '{1500, -3000, 200};
        bq = '{500, 500, 100};
        set_ops(ba[0], bb[0], bs[0], bc[0]);
        start = 1'b1;
        for (int r = 0; r < 3; r++) begin
            tick();
            scramble();
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("b2b%0d.busy", r), int'(busy), 1);
                chk($sformatf("b2b%0d.early_done", r), int'(done), 0);
                tick();
            end
            chk($sformatf("b2b%0d.done", r), int'(done), 1);
            chk($sformatf("b2b%0d.d", r), int'(d), bd[r]);
            chk($sformatf("b2b%0d.q", r), int'(q), bq[r]);
            if (r < 2) begin
                set_ops(ba[r+1], bb[r+1], bs[r+1], bc[r+1]);
            end else begin
                start = 1'b0;
            end
        end
        tick();
        chk("b2b.tail_done", int'(done), 0);
        chk("b2b.tail_busy", int'(busy), 0);

        set_ops(1000, 2000, 16384, 16384);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rstb = 1'b1;
        tick();
        rstb = 1'b0;
        chk("abort.busy", int'(busy), 0);
        chk("abort.d", int'(d), 0);
        chk("abort.q", int'(q), 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("abort.no_done", int'(done), 0);
        end
        run_op("after_abort", 16384, -8192, 0, 32768, 16384, -8192);

        set_ops(1000, 2000, 16384, 16384);
        rstb  = 1'b1;
        start = 1'b1;
        tick();
        rstb  = 1'b0;
        start = 1'b0;
        chk("rst_vs_start.busy", int'(busy), 0);
        chk("rst_vs_start.d", int'(d), 0);
        tick();
        chk("rst_vs_start.idle", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
